icache_refill_ctrl: RTL
=======================

// Module: icache_refill_ctrl
// PURPOSE
//  Miss/refill sequencer for the L1 instruction cache in the fetch stage.
//  - On a fetch miss: stalls the PC and requests one 128-bit line from instruction memory.
//  - Writes the returned line into the cache, then releases the stall.
//  - Sits between PC/InstCache (hit, address) and InstMemory (line source).
//  - Owns miss statistics and memory-timeout detection.
// PARAMETERS
//  ADDR_W       32   fetch/memory address width
//  LINE_W       128  cache line width; 4 x 32-bit words
//  OFF_W        4    byte-offset bits of a line; line address = {addr[ADDR_W-1:OFF_W], OFF_W'b0}
//  TIMEOUT_CYC  64   max cycles in REQ without mem_ready before error
// PORTS
//  Clk          in   1       clock, rising edge
//  Reset        in   1       asynchronous, active-high
//  fetch_addr   in   ADDR_W  current PC (from PC register)
//  fetch_valid  in   1       fetch_addr is a live fetch this cycle
//  cache_hit    in   1       InstCache hit for fetch_addr
//  flush        in   1       branch/redirect: abandon outstanding refill
//  mem_req      out  1       line request to instruction memory
//  mem_addr     out  ADDR_W  line-aligned request address
//  mem_ready    in   1       mem_line valid; completes the request
//  mem_line     in   LINE_W  returned line
//  fill_we      out  1       one-cycle cache line write strobe
//  fill_addr    out  ADDR_W  line-aligned fill address
//  fill_line    out  LINE_W  line data to write
//  pc_stall     out  1       hold the PC register
//  busy         out  1       state != IDLE
//  timeout_err  out  1       sticky memory-timeout flag
//  miss_count   out  32      saturating count of refills started
// BEHAVIOUR
//  Reset (async): state=IDLE; mem_req=0; fill_we=0; pc_stall=0; busy=0;
//    timeout_err=0; miss_count=0; addr/line registers=0. Effective mid-refill.
//  miss = fetch_valid & ~cache_hit.
//  pc_stall (combinational) = (IDLE & miss & ~flush) | state in {REQ, DRAIN, FILL, RESUME}.
//  States:
//  - IDLE: on miss & ~flush, latch line_addr, increment miss_count (saturates at 32'hFFFF_FFFF), go REQ.
//    flush in IDLE is a no-op.
//  - REQ: mem_req=1; mem_addr=line_addr, held stable.
//    - mem_ready: capture mem_line, go FILL.
//    - flush & ~mem_ready: go DRAIN. No cancel exists; the in-flight request must complete.
//    - flush & mem_ready in the same cycle: drop the line, go IDLE.
//    - Timer counts REQ cycles. Timer == TIMEOUT_CYC-1 & ~mem_ready: set timeout_err, go ERR.
//  - DRAIN: mem_req=1 until mem_ready, then go IDLE with no fill. DRAIN is also timed and goes ERR on timeout.
//  - FILL: fill_we=1 for exactly 1 cycle with fill_addr/fill_line; go RESUME.
//  - RESUME: 1-cycle bubble so the cache read reflects the fill; go IDLE.
//    Re-check in IDLE: a miss on the same address starts a new refill.
//  - ERR: terminal; mem_req=0, pc_stall=1. Exit only by Reset.
//  Latency: miss seen in cycle 0 -> mem_req from cycle 1.
//    mem_ready in cycle N -> fill_we in N+1 -> stall released in N+3 (IDLE).
//  flush arriving in FILL or RESUME is ignored; the fill is valid cache content.
//  The timer is cleared on entry to REQ and to DRAIN.
// STRUCTURE
//  Package ifetch_pkg:
//  - state enum: IDLE, REQ, DRAIN, FILL, RESUME, ERR.
//  - LINE_W, OFF_W, WORDS_PER_LINE=4.
//  - line_align() function.
//  Sub-module refill_timer: clear/enable/expire counter, width $clog2(TIMEOUT_CYC).
//  One FSM plus datapath registers in the top module.
// TESTING
//  1. Hit stream: cache_hit=1 for 20 fetches -> mem_req never 1, pc_stall=0, miss_count=0.
//  2. Miss at 0x0000_0104, mem_ready after 3 cycles with line 128'hA..D:
//     - mem_addr=0x0000_0100;
//     - one fill_we with that line;
//     - stall released 3 cycles after ready;
//     - miss_count=1.
//  3. flush 1 cycle into REQ, mem_ready 2 cycles later -> DRAIN, no fill_we, IDLE after ready.
//  4. mem_ready never asserted -> timeout_err=1 exactly at TIMEOUT_CYC=64 REQ cycles;
//     stays in ERR with pc_stall=1 until Reset.
//  5. Reset pulsed mid-REQ (asynchronously, between edges) ->
//     - mem_req drops before the next edge;
//     - all outputs return to reset values.
//  6. Back-to-back misses 0x100 then 0x200 -> two clean refills, miss_count=2;
//     preload miss_count=32'hFFFF_FFFF via force -> stays saturated after a further miss.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch refill path.
package ifetch_pkg;
  localparam int ADDR_W         = 32;
  localparam int OFF_W          = 4;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_W         = WORDS_PER_LINE * WORD_W;
  localparam int TIMEOUT_CYC    = 64;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DRAIN,
    FILL,
    RESUME,
    ERR
  } refillState_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/refill_timer.sv
// Cycle counter for an outstanding memory request; expire flags the last allowed cycle.
module refill_timer
  import ifetch_pkg::*;
#(
  parameter int TIMEOUT_CYC = ifetch_pkg::TIMEOUT_CYC
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = enable && (count == CNT_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/icache_refill_ctrl.sv
// L1 instruction-cache miss/refill sequencer: stalls fetch, pulls one line from
// instruction memory, writes it into the cache and tracks misses/timeouts.
//   state  | meaning
//   IDLE   | no refill outstanding
//   REQ    | line requested, waiting for mem_ready
//   DRAIN  | refill abandoned by flush, waiting out the in-flight request
//   FILL   | one-cycle cache write of the returned line
//   RESUME | bubble so the cache read sees the fill
//   ERR    | memory timed out; held until Reset
module icache_refill_ctrl
  import ifetch_pkg::*;
#(
  parameter int TIMEOUT_CYC = ifetch_pkg::TIMEOUT_CYC
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_valid,
  input  logic              cache_hit,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_line,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_line,
  output logic              pc_stall,
  output logic              busy,
  output logic              timeout_err,
  output logic [31:0]       miss_count
);
  refillState_t      state, nextState;
  logic [ADDR_W-1:0] lineAddr;
  logic [LINE_W-1:0] lineData;
  logic [31:0]       missCount;
  logic              timeoutErr;
  logic              miss, startRefill, timerClear, timerEnable, timerExpire;

  assign miss        = fetch_valid & ~cache_hit;
  assign startRefill = (state == IDLE) & miss & ~flush;
  assign timerEnable = (state == REQ) | (state == DRAIN);
  assign timerClear  = ((nextState == REQ) & (state != REQ)) |
                       ((nextState == DRAIN) & (state != DRAIN));

  refill_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) uTimer (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (timerClear),
    .enable (timerEnable),
    .expire (timerExpire)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startRefill) nextState = REQ;
      REQ: begin
        // Same-cycle flush and ready: the line is stale, drop it.
        if (mem_ready)        nextState = flush ? IDLE : FILL;
        else if (flush)       nextState = DRAIN;
        else if (timerExpire) nextState = ERR;
      end
      DRAIN: begin
        if (mem_ready)        nextState = IDLE;
        else if (timerExpire) nextState = ERR;
      end
      FILL:    nextState = RESUME;
      RESUME:  nextState = IDLE;
      ERR:     nextState = ERR;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lineAddr   <= '0;
      lineData   <= '0;
      missCount  <= '0;
      timeoutErr <= 1'b0;
    end else begin
      if (startRefill) begin
        lineAddr <= line_align(fetch_addr);
        if (missCount != 32'hFFFF_FFFF) missCount <= missCount + 32'd1;
      end
      if ((state == REQ) && mem_ready && !flush) lineData <= mem_line;
      if ((nextState == ERR) && (state != ERR)) timeoutErr <= 1'b1;
    end
  end

  assign mem_req     = timerEnable;
  assign mem_addr    = lineAddr;
  assign fill_we     = (state == FILL);
  assign fill_addr   = lineAddr;
  assign fill_line   = lineData;
  assign pc_stall    = startRefill | (state != IDLE);
  assign busy        = (state != IDLE);
  assign timeout_err = timeoutErr;
  assign miss_count  = missCount;
endmodule
